mux16_1_tree_reg: RTL and testbench

- 16-to-1 single-bit (parameterisable width) multiplexer built as a balanced binary tree of 2-to-1 mux cells, elaborated with generate loops.
- Four tree levels, 15 cells in total.
- Tree output is captured in one output register, giving a clean registered select path for downstream synchronous logic.
- Used wherever a 4-bit index picks one of 16 lanes or flags.

---
 rtl/mux16_pkg.sv | 8 +
 rtl/mux2_cell.sv | 13 +
 rtl/mux16_1_tree_reg.sv | 61 ++++++
 tb/tb_mux16_1_tree_reg.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mux16_pkg.sv
// Shared constants for the 16:1 registered mux tree.
package mux16_pkg;

    localparam int unsigned N_IN        = 16;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned TREE_LEVELS = 4;

endpackage : mux16_pkg

// File: rtl/mux2_cell.sv
// Combinational 2-to-1 mux cell, the building block of the select tree.
module mux2_cell #(
    parameter int unsigned DATA_W = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              s,
    output logic [DATA_W-1:0] o
);

    assign o = s ? b : a;

endmodule : mux2_cell

// File: rtl/mux16_1_tree_reg.sv
// 16:1 mux as a balanced tree of mux2_cell instances, with the result registered.
module mux16_1_tree_reg
    import mux16_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*DATA_W-1:0] in,
    input  logic [SEL_W-1:0]       select,
    output logic [DATA_W-1:0]      y
);

    logic [DATA_W-1:0] tree_out;
    logic [DATA_W-1:0] y_d;
    logic [DATA_W-1:0] y_q;

    // Each level owns its own output array; level L reads level L-1's array by scope name.
    for (genvar L = 0; L < TREE_LEVELS; L++) begin : g_lvl
        logic [DATA_W-1:0] lvl_o [N_IN >> (L + 1)];

        for (genvar j = 0; j < (N_IN >> (L + 1)); j++) begin : g_cell
            if (L == 0) begin : g_leaf
                mux2_cell #(
                    .DATA_W (DATA_W)
                ) u_cell (
                    .a (in[(2*j)*DATA_W +: DATA_W]),
                    .b (in[(2*j+1)*DATA_W +: DATA_W]),
                    .s (select[L]),
                    .o (lvl_o[j])
                );
            end else begin : g_inner
                mux2_cell #(
                    .DATA_W (DATA_W)
                ) u_cell (
                    .a (g_lvl[L-1].lvl_o[2*j]),
                    .b (g_lvl[L-1].lvl_o[2*j+1]),
                    .s (select[L]),
                    .o (lvl_o[j])
                );
            end
        end
    end

    assign tree_out = g_lvl[TREE_LEVELS-1].lvl_o[0];

    always_comb begin
        y_d = tree_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule : mux16_1_tree_reg

// File: tb/tb_mux16_1_tree_reg.sv
// Directed and random checks of mux16_1_tree_reg at DATA_W=1 and DATA_W=4.
module tb_mux16_1_tree_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in1;
    logic [3:0]  sel1;
    logic [0:0]  y1;
    logic [63:0] in4;
    logic [3:0]  sel4;
    logic [3:0]  y4;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    mux16_1_tree_reg #(
        .DATA_W (1)
    ) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in1),
        .select (sel1),
        .y      (y1)
    );

    mux16_1_tree_reg #(
        .DATA_W (4)
    ) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in4),
        .select (sel4),
        .y      (y4)
    );

    // Reference: the selected lane is simply lane number `sel` of the packed bus.
    function automatic logic [0:0] model1(input logic [15:0] v, input int unsigned sel);
        return v[sel];
    endfunction

    function automatic logic [3:0] model4(input logic [63:0] v, input int unsigned sel);
        logic [63:0] sh;
        sh = v >> (4 * sel);
        return sh[3:0];
    endfunction

    task automatic step1(input logic [15:0] v, input logic [3:0] s, input logic r, input string tag);
        logic [0:0] exp;
        in1   = v;
        sel1  = s;
        rst_n = r;
        @(posedge clk);
        #1;
        exp = r ? model1(v, int'(s)) : 1'b0;
        checks++;
        assert (y1 === exp) else begin
            errors++;
            $error("FAIL %s: y=%0h expected %0h", tag, y1, exp);
        end
    endtask

    task automatic step4(input logic [63:0] v, input logic [3:0] s, input logic r, input string tag);
        logic [3:0] exp;
        in4   = v;
        sel4  = s;
        rst_n = r;
        @(posedge clk);
        #1;
        exp = r ? model4(v, int'(s)) : 4'h0;
        checks++;
        assert (y4 === exp) else begin
            errors++;
            $error("FAIL %s: y=%0h expected %0h", tag, y4, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] v16;
        logic [63:0] v64;
        in1   = 16'h0;
        sel1  = 4'h0;
        in4   = 64'h0;
        sel4  = 4'h0;
        rst_n = 1'b0;

        for (int i = 0; i < 3; i++)
            step1(16'hFFFF, 4'hF, 1'b0, $sformatf("reset_%0d", i));
        step1(16'hFFFF, 4'hF, 1'b1, "reset_release");

        for (int i = 0; i < 16; i++) begin
            v16 = 16'hA5A5 ^ 16'(i);
            if (i == 7) begin
                step1(v16, 4'(i), 1'b0, "sweep_midreset");
            end
            step1(v16, 4'(i), 1'b1, $sformatf("sweep_%0d", i));
        end

        for (int k = 0; k < 16; k++) begin
            v16 = 16'h1 << k;
            step1(v16, 4'(k), 1'b1, $sformatf("onehot_hit_%0d", k));
            step1(v16, 4'((k + 1) % 16), 1'b1, $sformatf("onehot_miss_%0d", k));
        end

        for (int c = 0; c < 8; c++)
            step1(16'h8001, (c % 2 == 0) ? 4'h0 : 4'hF, 1'b1, $sformatf("b2b_8001_%0d", c));
        for (int c = 0; c < 8; c++)
            step1(16'h0001, (c % 2 == 0) ? 4'h0 : 4'hF, 1'b1, $sformatf("b2b_0001_%0d", c));

        for (int c = 0; c < 200; c++) begin
            v16 = 16'($urandom);
            step1(v16, 4'($urandom_range(0, 15)), ($urandom_range(0, 19) != 0),
                  $sformatf("rand1_%0d", c));
        end

        v64 = 64'hFEDC_BA98_7654_3210;
        for (int k = 0; k < 16; k++)
            step4(v64, 4'(k), 1'b1, $sformatf("width4_%0d", k));
        step4(v64, 4'hF, 1'b0, "width4_reset");

        for (int c = 0; c < 200; c++) begin
            v64 = {32'($urandom), 32'($urandom)};
            step4(v64, 4'($urandom_range(0, 15)), ($urandom_range(0, 19) != 0),
                  $sformatf("rand4_%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux16_1_tree_reg
